// File: rtl/saltos_pkg.sv
// Shared definitions for the branch/PC unit: jump codes, PC-source
// encodings, control states and ALU flag bit positions.
package saltos_pkg;

  // Jump/branch codes driven by the control unit
  localparam logic [3:0] COD_NOP  = 4'b0000;
  localparam logic [3:0] COD_JMP  = 4'b0001;
  localparam logic [3:0] COD_JZ   = 4'b0010;
  localparam logic [3:0] COD_JNZ  = 4'b0011;
  localparam logic [3:0] COD_JC   = 4'b0100;
  localparam logic [3:0] COD_JNC  = 4'b0101;
  localparam logic [3:0] COD_JN   = 4'b0110;
  localparam logic [3:0] COD_JNN  = 4'b0111;
  localparam logic [3:0] COD_CALL = 4'b1000;
  localparam logic [3:0] COD_RET  = 4'b1001;
  localparam logic [3:0] COD_BRA  = 4'b1010;
  localparam logic [3:0] COD_BRZ  = 4'b1011;
  localparam logic [3:0] COD_HALT = 4'b1100;

  // Source of the most recent PC update
  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_ABS = 2'b01;
  localparam logic [1:0] SEL_REL = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  // Control states; HALT and FAULT are only left through reset
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } estado_t;

  // Bit positions inside the ALU status flags
  localparam int BAN_Z = 0;
  localparam int BAN_C = 1;
  localparam int BAN_N = 2;

endpackage

// File: rtl/saltos_pila_ret.sv
// Return-address LIFO for the branch/PC unit. Register array with a
// level counter that doubles as the write pointer. Push on a full stack
// and pop on an empty one are ignored here; the caller turns them into
// a fault. Contents are not reset, only the level counter is.
module saltos_pila_ret
  import saltos_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  localparam int IDX_W      = $clog2(STACK_DEPTH),
  localparam int LVL_W      = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] data_out,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // Next free slot is the level itself; top of stack sits one below it
  assign wr_idx   = level[IDX_W-1:0];
  assign rd_idx   = wr_idx - IDX_W'(1);
  assign data_out = mem[rd_idx];
  assign full     = (level == LVL_W'(STACK_DEPTH));
  assign empty    = (level == '0);

  // Occupancy counter; async reset empties the stack, discarding any push in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + LVL_W'(1);
    end else if (pop && !empty) begin
      level <= level - LVL_W'(1);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= data_in;
    end
  end

endmodule

// File: rtl/saltos_pc_pila.sv
// Registered branch/PC unit for the teaching microprocessor. Owns the
// program counter, evaluates the 4-bit jump code against the Z/C/N flags,
// and supports CALL/RET through a return-address stack, a HALT state and
// a sticky FAULT state (stack overflow/underflow).
// Build option: define SALTOS_RELATIVOS_EN to enable the PC-relative codes
// BRA/BRZ; without it those codes run as NOP and no relative adder exists.
module saltos_pc_pila
  import saltos_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0,
  localparam int LVL_W      = $clog2(STACK_DEPTH) + 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Enable,
  input  logic [3:0]        i_Control_Salto,
  input  logic [2:0]        i_BanEstado,
  input  logic [ADDR_W-1:0] i_Dir_Salto,
  output logic [ADDR_W-1:0] o_PC,
  output logic [1:0]        o_Salto_PC,
  output logic              o_Salto_Tomado,
  output logic [LVL_W-1:0]  o_Pila_Nivel,
  output logic              o_Halt,
  output logic              o_Error
);

  localparam logic [ADDR_W-1:0] PC_INI = ADDR_W'(RESET_PC);

  estado_t           estado;
  estado_t           estado_sig;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_sig;
  logic [ADDR_W-1:0] pc_inc;
  logic [1:0]        sel;
  logic [1:0]        sel_sig;
  logic              tomado;
  logic              tomado_sig;
  logic              ejecuta;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pila_out;
  logic              pila_llena;
  logic              pila_vacia;

  // Conditional absolute jumps: decide whether the code is taken for these flags
  function automatic logic cond_ok(input logic [3:0] cod, input logic [2:0] ban);
    case (cod)
      COD_JMP: cond_ok = 1'b1;
      COD_JZ:  cond_ok = ban[BAN_Z];
      COD_JNZ: cond_ok = !ban[BAN_Z];
      COD_JC:  cond_ok = ban[BAN_C];
      COD_JNC: cond_ok = !ban[BAN_C];
      COD_JN:  cond_ok = ban[BAN_N];
      COD_JNN: cond_ok = !ban[BAN_N];
      default: cond_ok = 1'b0;
    endcase
  endfunction

  // Sequential successor wraps modulo 2^ADDR_W
  assign pc_inc  = pc + ADDR_W'(1);
  assign ejecuta = i_Enable && (estado == ST_RUN);

`ifdef SALTOS_RELATIVOS_EN
  logic [ADDR_W-1:0] pc_rel;
  // Offset is already ADDR_W wide, so modulo addition is its sign extension
  assign pc_rel = pc + i_Dir_Salto;
`endif

  saltos_pila_ret #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_pila (
    .clk      (i_Clk),
    .rst      (i_Reset),
    .push     (push),
    .pop      (pop),
    .data_in  (pc_inc),
    .data_out (pila_out),
    .level    (o_Pila_Nivel),
    .full     (pila_llena),
    .empty    (pila_vacia)
  );

  // Decode the current code into next PC, PC source, taken pulse, stack ops and state
  always_comb begin
    pc_sig     = pc;
    sel_sig    = sel;
    tomado_sig = 1'b0;
    estado_sig = estado;
    push       = 1'b0;
    pop        = 1'b0;
    if (ejecuta) begin
      pc_sig  = pc_inc;
      sel_sig = SEL_SEQ;
      case (i_Control_Salto)
        COD_JMP, COD_JZ, COD_JNZ, COD_JC, COD_JNC, COD_JN, COD_JNN: begin
          if (cond_ok(i_Control_Salto, i_BanEstado)) begin
            pc_sig     = i_Dir_Salto;
            sel_sig    = SEL_ABS;
            tomado_sig = 1'b1;
          end
        end
        COD_CALL: begin
          if (pila_llena) begin
            pc_sig     = pc;
            sel_sig    = sel;
            estado_sig = ST_FAULT;
          end else begin
            push       = 1'b1;
            pc_sig     = i_Dir_Salto;
            sel_sig    = SEL_ABS;
            tomado_sig = 1'b1;
          end
        end
        COD_RET: begin
          if (pila_vacia) begin
            pc_sig     = pc;
            sel_sig    = sel;
            estado_sig = ST_FAULT;
          end else begin
            pop        = 1'b1;
            pc_sig     = pila_out;
            sel_sig    = SEL_RET;
            tomado_sig = 1'b1;
          end
        end
`ifdef SALTOS_RELATIVOS_EN
        COD_BRA: begin
          pc_sig     = pc_rel;
          sel_sig    = SEL_REL;
          tomado_sig = 1'b1;
        end
        COD_BRZ: begin
          if (i_BanEstado[BAN_Z]) begin
            pc_sig     = pc_rel;
            sel_sig    = SEL_REL;
            tomado_sig = 1'b1;
          end
        end
`endif
        COD_HALT: begin
          pc_sig     = pc;
          sel_sig    = sel;
          estado_sig = ST_HALT;
        end
        default: ;
      endcase
    end
  end

  // State, PC and PC-source registers; all outputs update on the same edge
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      estado <= ST_RUN;
      pc     <= PC_INI;
      sel    <= SEL_SEQ;
      tomado <= 1'b0;
    end else begin
      estado <= estado_sig;
      pc     <= pc_sig;
      sel    <= sel_sig;
      tomado <= tomado_sig;
    end
  end

  assign o_PC           = pc;
  assign o_Salto_PC     = sel;
  assign o_Salto_Tomado = tomado;
  assign o_Halt         = (estado != ST_RUN);
  assign o_Error        = (estado == ST_FAULT);

endmodule

// File: tb/tb_saltos_pc_pila.sv
// Directed bench for saltos_pc_pila (ADDR_W=8, STACK_DEPTH=4, RESET_PC=0).
// A vector table walks one continuous program from reset; hand-written
// sequences cover RET underflow, HALT and asynchronous reset mid-program.
module tb_saltos_pc_pila;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] cod = 4'h0;
  logic [2:0] ban = 3'b000;
  logic [7:0] dir = 8'h00;

  logic [7:0] o_pc;
  logic [1:0] o_sel;
  logic       o_tom;
  logic [2:0] o_lvl;
  logic       o_halt;
  logic       o_err;

  int tests  = 0;
  int failed = 0;

  saltos_pc_pila #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_PC    (0)
  ) dut (
    .i_Clk           (clk),
    .i_Reset         (rst),
    .i_Enable        (en),
    .i_Control_Salto (cod),
    .i_BanEstado     (ban),
    .i_Dir_Salto     (dir),
    .o_PC            (o_pc),
    .o_Salto_PC      (o_sel),
    .o_Salto_Tomado  (o_tom),
    .o_Pila_Nivel    (o_lvl),
    .o_Halt          (o_halt),
    .o_Error         (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] cod;
    logic [2:0] ban;
    logic [7:0] dir;
    logic [7:0] pc;
    logic [1:0] sel;
    logic       tom;
    logic [2:0] lvl;
    logic       halt;
    logic       err;
  } vec_t;

`ifdef SALTOS_RELATIVOS_EN
  localparam logic [7:0] BRA_PC  = 8'h03;
  localparam logic [1:0] BRA_SEL = 2'b10;
  localparam logic       BRA_TOM = 1'b1;
  localparam logic [7:0] BRZ_PC  = 8'h04;
`else
  localparam logic [7:0] BRA_PC  = 8'hFF;
  localparam logic [1:0] BRA_SEL = 2'b00;
  localparam logic       BRA_TOM = 1'b0;
  localparam logic [7:0] BRZ_PC  = 8'h00;
`endif

  vec_t vt[$];

  function automatic vec_t mk(input logic e, input logic [3:0] c, input logic [2:0] b,
                              input logic [7:0] d, input logic [7:0] p, input logic [1:0] s,
                              input logic t, input logic [2:0] l, input logic h, input logic r);
    vec_t v;
    v.en = e; v.cod = c; v.ban = b; v.dir = d;
    v.pc = p; v.sel = s; v.tom = t; v.lvl = l; v.halt = h; v.err = r;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] pc, input logic [1:0] sel,
                       input logic tom, input logic [2:0] lvl, input logic halt, input logic err);
    tests++;
    if ({o_pc, o_sel, o_tom, o_lvl, o_halt, o_err} !== {pc, sel, tom, lvl, halt, err}) begin
      failed++;
      $display("FAIL %s: got pc=%h sel=%b tom=%b lvl=%0d halt=%b err=%b, want pc=%h sel=%b tom=%b lvl=%0d halt=%b err=%b",
               nm, o_pc, o_sel, o_tom, o_lvl, o_halt, o_err, pc, sel, tom, lvl, halt, err);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] c, input logic [2:0] b, input logic [7:0] d);
    en = e; cod = c; ban = b; dir = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; cod = 4'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_state", 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    //           en  cod      ban     dir     pc     sel    tom   lvl   halt  err
    vt.push_back(mk(1, 4'b0000, 3'b000, 8'h00, 8'h01, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0)); // NOP
    vt.push_back(mk(1, 4'b0000, 3'b000, 8'h00, 8'h02, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0)); // NOP
    vt.push_back(mk(1, 4'b0000, 3'b000, 8'h00, 8'h03, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0)); // NOP
    vt.push_back(mk(1, 4'b0001, 3'b000, 8'h10, 8'h10, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0)); // JMP 10
    vt.push_back(mk(1, 4'b0010, 3'b001, 8'h40, 8'h40, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0)); // JZ taken
    vt.push_back(mk(1, 4'b0001, 3'b000, 8'h10, 8'h10, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0)); // JMP 10
    vt.push_back(mk(1, 4'b0010, 3'b000, 8'h40, 8'h11, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0)); // JZ not taken
    vt.push_back(mk(1, 4'b0011, 3'b000, 8'h50, 8'h50, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0)); // JNZ taken
    vt.push_back(mk(1, 4'b0100, 3'b010, 8'h60, 8'h60, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0)); // JC taken
    vt.push_back(mk(1, 4'b0101, 3'b010, 8'h70, 8'h61, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0)); // JNC not taken
    vt.push_back(mk(1, 4'b0110, 3'b100, 8'h20, 8'h20, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0)); // JN taken
    vt.push_back(mk(1, 4'b1000, 3'b000, 8'h80, 8'h80, 2'b01, 1'b1, 3'd1, 1'b0, 1'b0)); // CALL 80
    vt.push_back(mk(1, 4'b1001, 3'b000, 8'h00, 8'h21, 2'b11, 1'b1, 3'd0, 1'b0, 1'b0)); // RET -> 21
    vt.push_back(mk(0, 4'b0001, 3'b000, 8'hAA, 8'h21, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0)); // disabled JMP
    vt.push_back(mk(1, 4'b1101, 3'b111, 8'hAA, 8'h22, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0)); // reserved
    vt.push_back(mk(1, 4'b0111, 3'b100, 8'h30, 8'h23, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0)); // JNN not taken
    vt.push_back(mk(1, 4'b0001, 3'b000, 8'hFE, 8'hFE, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0)); // JMP FE
    vt.push_back(mk(1, 4'b1010, 3'b000, 8'h05, BRA_PC, BRA_SEL, BRA_TOM, 3'd0, 1'b0, 1'b0)); // BRA +5
    vt.push_back(mk(1, 4'b1011, 3'b000, 8'h10, BRZ_PC, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0)); // BRZ Z=0
    vt.push_back(mk(1, 4'b0001, 3'b000, 8'h00, 8'h00, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0)); // JMP 00
    vt.push_back(mk(1, 4'b1000, 3'b000, 8'h90, 8'h90, 2'b01, 1'b1, 3'd1, 1'b0, 1'b0)); // CALL 1
    vt.push_back(mk(1, 4'b1000, 3'b000, 8'hA0, 8'hA0, 2'b01, 1'b1, 3'd2, 1'b0, 1'b0)); // CALL 2
    vt.push_back(mk(1, 4'b1000, 3'b000, 8'hB0, 8'hB0, 2'b01, 1'b1, 3'd3, 1'b0, 1'b0)); // CALL 3
    vt.push_back(mk(1, 4'b1000, 3'b000, 8'hC0, 8'hC0, 2'b01, 1'b1, 3'd4, 1'b0, 1'b0)); // CALL 4 full
    vt.push_back(mk(1, 4'b1000, 3'b000, 8'hD0, 8'hC0, 2'b01, 1'b0, 3'd4, 1'b1, 1'b1)); // overflow
    vt.push_back(mk(1, 4'b0001, 3'b000, 8'h11, 8'hC0, 2'b01, 1'b0, 3'd4, 1'b1, 1'b1)); // ignored
    vt.push_back(mk(1, 4'b1001, 3'b000, 8'h00, 8'hC0, 2'b01, 1'b0, 3'd4, 1'b1, 1'b1)); // ignored

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].en, vt[i].cod, vt[i].ban, vt[i].dir);
      check($sformatf("vec%0d", i), vt[i].pc, vt[i].sel, vt[i].tom, vt[i].lvl, vt[i].halt, vt[i].err);
    end

    // RET on an empty stack faults and locks the unit
    do_reset();
    step(1'b1, 4'b1001, 3'b000, 8'h00);
    check("ret_underflow", 8'h00, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b1, 4'b0001, 3'b000, 8'h33);
    check("fault_locked", 8'h00, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1);

    // HALT holds the PC and blocks further codes, without the error flag
    do_reset();
    step(1'b1, 4'b0000, 3'b000, 8'h00);
    check("pre_halt_nop", 8'h01, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 4'b1100, 3'b000, 8'h00);
    check("halt", 8'h01, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 3'b000, 8'h44);
    check("halt_locked", 8'h01, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges clears PC and stack at once
    do_reset();
    step(1'b1, 4'b1000, 3'b000, 8'h40);
    check("call_before_rst", 8'h40, 2'b01, 1'b1, 3'd1, 1'b0, 1'b0);
    en = 1'b1; cod = 4'b1000; dir = 8'h60;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 4'b0000, 3'b000, 8'h00);
    check("after_async_rst", 8'h01, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
